// File: rtl/bus_server_if.sv
// rtl/bus_server_if.sv - rq/ack client bus bundle between a client and a bus_server
// Signals:
//   address    client -> server  request address
//   rq         client -> server  request, held until ack is seen
//   wr_ni      client -> server  1 = read, 0 = write
//   dataW      client -> server  write data
//   ack        server -> client  one-cycle access-complete pulse
//   busy       server -> client  server is not idle
//   access_cnt server -> client  completed accesses since reset
interface bus_server_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  rq;
  logic                  wr_ni;
  logic [DATA_WIDTH-1:0] dataW;
  logic                  ack;
  logic                  busy;
  logic [15:0]           access_cnt;

  modport master (
    output address, rq, wr_ni, dataW,
    input  ack, busy, access_cnt
  );

  modport slave (
    input  address, rq, wr_ni, dataW,
    output ack, busy, access_cnt
  );
endinterface

// File: rtl/bus_server.sv
// rtl/bus_server.sv - responder end of the rq/ack client bus with a latency-delayed register bank
// Ports:
//   clk    in   clock, all logic on posedge
//   reset  in   synchronous, active-low
//   bus    slave modport of bus_server_if (address/rq/wr_ni/dataW in, ack/busy/access_cnt out)
//   dataR  out  read data while ack is high on a read, high impedance otherwise
module bus_server #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 4,
  parameter int ADDR_SPACE_BEGINNING = 0,
  parameter int ADDR_SPACE_END       = 3,
  parameter int ACCESS_LATENCY       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_server_if.slave           bus,
  output logic [DATA_WIDTH-1:0] dataR
);

  localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_wr_ni;
  logic [DATA_WIDTH-1:0] r_dataW;
  logic [15:0]           r_access_cnt;
  logic [DATA_WIDTH-1:0] r_bank [DEPTH];

  logic [ADDR_WIDTH:0]   w_diff;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_capture;
  logic                  w_commit;

  // One extra bit on the subtraction: a borrow means the address is below
  // the window, so a single unsigned compare covers the upper bound.
  assign w_diff     = {1'b0, bus.address} - (ADDR_WIDTH+1)'(ADDR_SPACE_BEGINNING);
  assign w_in_range = !w_diff[ADDR_WIDTH] &&
                      (w_diff[ADDR_WIDTH-1:0] <= ADDR_WIDTH'(DEPTH - 1));
  assign w_idx      = w_diff[IDX_W-1:0];

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rq && w_in_range) begin
          w_capture    = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        w_commit     = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        // Holding here until rq drops keeps a lingering rq from being
        // mistaken for a second request.
        if (!bus.rq) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wr_ni      <= 1'b0;
      r_dataW      <= '0;
      r_access_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_idx   <= w_idx;
        r_wr_ni <= bus.wr_ni;
        r_dataW <= bus.dataW;
        r_cnt   <= CNT_W'(ACCESS_LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_access_cnt <= r_access_cnt + 16'd1;
        if (!r_wr_ni) begin
          r_bank[r_idx] <= r_dataW;
        end
      end
    end
  end

  assign bus.ack        = (r_state == S_ACK);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.access_cnt = r_access_cnt;

  // Read data comes straight from the bank so a read issued right after a
  // write to the same word sees the committed value.
  assign dataR = (r_state == S_ACK && r_wr_ni) ? r_bank[r_idx] : 'z;

endmodule

// File: tb/tb_bus_server.sv
// tb/tb_bus_server.sv - self-checking bench for bus_server against a cycle-number reference model
module tb_bus_server;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int BEG = 0;
  localparam int END = 3;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           reset;
  wire  [DW-1:0]  dataR;

  bus_server_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_server #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ADDR_SPACE_BEGINNING(BEG), .ADDR_SPACE_END(END),
    .ACCESS_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .dataR (dataR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request is remembered by the edge number
  // that captured it; ack, write commit and release follow from that number.
  int          m_cyc     = 0;
  bit          m_started = 0;
  bit          m_active  = 0;
  int          m_acc     = 0;
  bit          m_wr_ni   = 0;
  int          m_idx     = 0;
  logic [7:0]  m_data    = '0;
  logic [7:0]  m_bank [4];
  logic [15:0] m_cnt     = '0;

  always @(posedge clk) begin
    m_cyc++;
    if (!reset) begin
      m_started = 1;
      m_active  = 0;
      m_cnt     = '0;
      for (int i = 0; i < 4; i++) m_bank[i] = '0;
    end else if (!m_active) begin
      if (bus.rq && int'(bus.address) >= BEG && int'(bus.address) <= END) begin
        m_active = 1;
        m_acc    = m_cyc;
        m_wr_ni  = bus.wr_ni;
        m_idx    = int'(bus.address) - BEG;
        m_data   = bus.dataW;
      end
    end else begin
      if (m_cyc == m_acc + LAT + 1) begin
        if (!m_wr_ni) m_bank[m_idx] = m_data;
        m_cnt = m_cnt + 16'd1;
      end else if (m_cyc > m_acc + LAT + 1 && !bus.rq) begin
        m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      logic exp_ack;
      exp_ack = m_active && (m_cyc == m_acc + LAT);
      chk("ack", bus.ack, exp_ack);
      chk("busy", bus.busy, m_active);
      chk("access_cnt", bus.access_cnt, m_cnt);
      if (exp_ack && m_wr_ni) chk("dataR", dataR, m_bank[m_idx]);
      if (bus.ack) n_ack++;
    end
  end

  task automatic access(input logic [3:0] a, input logic w, input logic [7:0] d,
                        input int hold, output logic [7:0] rd, output int lat);
    @(posedge clk); #1;
    bus.address = a; bus.wr_ni = w; bus.dataW = d; bus.rq = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ack && lat < 50);
    chk("ack_seen", bus.ack, 1'b1);
    rd = dataR;
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.rq = 1'b0; bus.address = AW'($urandom); bus.dataW = DW'($urandom);
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b0; bus.rq = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] wdat [4];
    int lat;
    int acks0;

    reset = 1'b0; bus.rq = 1'b0; bus.address = '0; bus.wr_ni = 1'b1; bus.dataW = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cnt", bus.access_cnt, 16'd0);

    // Write 0x5A to addr 2, then read it back.
    access(4'd2, 1'b0, 8'h5A, 0, rd, lat);
    chk("write_latency", lat, LAT + 2);
    chk("cnt_after_write", bus.access_cnt, 16'd1);
    access(4'd2, 1'b1, 8'h00, 0, rd, lat);
    chk("read_back_5a", rd, 8'h5A);
    chk("cnt_after_read", bus.access_cnt, 16'd2);

    // Out-of-range read held for 20 cycles.
    pulse_reset();
    acks0 = n_ack;
    @(posedge clk); #1;
    bus.address = 4'd5; bus.wr_ni = 1'b1; bus.rq = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("oor_no_ack", n_ack - acks0, 0);
    chk("oor_busy", bus.busy, 1'b0);
    chk("oor_cnt", bus.access_cnt, 16'd0);
    @(posedge clk); #1; bus.rq = 1'b0;

    // Reset while the write of 0xFF to addr 1 is waiting.
    acks0 = n_ack;
    @(posedge clk); #1;
    bus.address = 4'd1; bus.wr_ni = 1'b0; bus.dataW = 8'hFF; bus.rq = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.rq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    chk("rst_wait_no_ack", n_ack - acks0, 0);
    access(4'd1, 1'b1, 8'h00, 0, rd, lat);
    chk("rst_wait_read", rd, 8'h00);
    chk("rst_wait_cnt", bus.access_cnt, 16'd1);

    // rq held 5 cycles past ack yields one ack.
    acks0 = n_ack;
    access(4'd3, 1'b0, 8'h33, 5, rd, lat);
    chk("hold_single_ack", n_ack - acks0, 1);

    // Back-to-back writes then reads over the whole window.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      wdat[i] = DW'($urandom);
      access(AW'(i), 1'b0, wdat[i], 0, rd, lat);
    end
    for (int i = 0; i < 4; i++) begin
      access(AW'(i), 1'b1, 8'h00, 0, rd, lat);
      chk("b2b_read", rd, wdat[i]);
    end
    chk("b2b_cnt", bus.access_cnt, 16'd8);

    // Randomized traffic, including out-of-range requests.
    for (int k = 0; k < 80; k++) begin
      logic [3:0] a;
      a = AW'($urandom_range(0, 7));
      if (int'(a) <= END) begin
        access(a, 1'($urandom), DW'($urandom), $urandom_range(0, 3), rd, lat);
        chk("rand_latency", lat, LAT + 2);
      end else begin
        @(posedge clk); #1;
        bus.address = a; bus.wr_ni = 1'($urandom); bus.dataW = DW'($urandom); bus.rq = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 bus.rq = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
